// File: rtl/clas_pkg.sv
// Shared constants and helpers for the 4-bit carry look-ahead adder/subtractor.
// Holds the datapath width, operation-select encodings and the effective-B helper.
package clas_pkg;

  localparam int CLAS_WIDTH = 4;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  // Subtraction is a + ~b + 1, so B is inverted here and the +1 arrives as carry-in.
  function automatic logic [CLAS_WIDTH-1:0] clas_eff_b(
    input logic [CLAS_WIDTH-1:0] b,
    input logic                  sel
  );
    clas_eff_b = b ^ {CLAS_WIDTH{sel}};
  endfunction

endpackage

// File: rtl/clas_cla_gen.sv
// Flat carry look-ahead generator: every carry is a two-level sum of products of p/g/c0.
// Purely combinational, no ripple between carry terms.
module clas_cla_gen
  import clas_pkg::*;
(
  input  logic [CLAS_WIDTH-1:0] p,
  input  logic [CLAS_WIDTH-1:0] g,
  input  logic                  c0,
  output logic [CLAS_WIDTH:1]   c
);

  always_comb begin
    c = '0;

    c[1] = g[0]
         | (p[0] & c0);

    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & c0);

    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);

    c[4] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
  end

endmodule

// File: rtl/clas_4_bit.sv
// 4-bit look-ahead adder/subtractor (sel: 0 add, 1 subtract); c_out is carry, i.e. no-borrow on subtract.
// Combinational by default; CLAS_4BIT_REG_OUT_EN adds a 1-cycle output register with sync reset to 0.
module clas_4_bit
  import clas_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CLAS_WIDTH-1:0] a,
  input  logic [CLAS_WIDTH-1:0] b,
  input  logic                  sel,
  output logic [CLAS_WIDTH-1:0] result,
  output logic                  c_out
);

  logic [CLAS_WIDTH-1:0] bx;
  logic [CLAS_WIDTH-1:0] g;
  logic [CLAS_WIDTH-1:0] p;
  logic [CLAS_WIDTH:1]   c_hi;
  logic [CLAS_WIDTH:0]   c;
  logic [CLAS_WIDTH-1:0] result_d;
  logic                  c_out_d;

  always_comb begin
    bx = clas_eff_b(b, sel);
    g  = a & bx;
    p  = a ^ bx;
  end

  clas_cla_gen u_cla_gen (
    .p  (p),
    .g  (g),
    .c0 (sel),
    .c  (c_hi)
  );

  // The select bit doubles as carry-in: +1 completes the two's complement on subtract.
  assign c = {c_hi, sel};

  always_comb begin
    result_d = p ^ c[CLAS_WIDTH-1:0];
    c_out_d  = c[CLAS_WIDTH];
  end

`ifdef CLAS_4BIT_REG_OUT_EN

  logic [CLAS_WIDTH-1:0] result_q;
  logic                  c_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      c_out_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      c_out_q  <= c_out_d;
    end
  end

  assign result = result_q;
  assign c_out  = c_out_q;

`else

  // Clock and reset stay on the port list so both builds share one footprint.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};

  assign result = result_d;
  assign c_out  = c_out_d;

`endif

endmodule

// File: tb/tb_clas_4_bit.sv
// Directed table plus exhaustive sweep for clas_4_bit; adapts to the registered build when
// CLAS_4BIT_REG_OUT_EN is defined.
module tb_clas_4_bit;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       sel;
  logic [3:0] result;
  logic       c_out;

  int n_vec;
  int n_err;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic [3:0] exp_r;
    logic       exp_c;
  } vec_t;

  vec_t tbl [7];

  clas_4_bit dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .sel    (sel),
    .result (result),
    .c_out  (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] er, input logic ec);
    n_vec++;
    if (result !== er || c_out !== ec) begin
      n_err++;
      $display("FAIL %s: got result=%0d c_out=%0b, expected result=%0d c_out=%0b",
               name, result, c_out, er, ec);
    end
  endtask

  // Drives one operand set and waits until it is visible on the outputs.
  task automatic apply(input logic [3:0] ta, input logic [3:0] tb2, input logic ts);
    a   = ta;
    b   = tb2;
    sel = ts;
`ifdef CLAS_4BIT_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    a     = 4'd9;
    b     = 4'd8;
    sel   = 1'b0;

    tbl[0] = '{"add_3_5",     4'd3,  4'd5,  1'b0, 4'd8,  1'b0};
    tbl[1] = '{"add_wrap_15_1",  4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
    tbl[2] = '{"add_15_15",   4'd15, 4'd15, 1'b0, 4'd14, 1'b1};
    tbl[3] = '{"sub_5_3",     4'd5,  4'd3,  1'b1, 4'd2,  1'b1};
    tbl[4] = '{"sub_7_7",     4'd7,  4'd7,  1'b1, 4'd0,  1'b1};
    tbl[5] = '{"sub_borrow_3_5", 4'd3,  4'd5,  1'b1, 4'd14, 1'b0};
    tbl[6] = '{"sub_borrow_0_15", 4'd0,  4'd15, 1'b1, 4'd1,  1'b0};

`ifdef CLAS_4BIT_REG_OUT_EN
    @(posedge clk);
    #1;
    check("reset_cycle1", 4'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_cycle2", 4'd0, 1'b0);
    rst = 1'b0;
    #1;
    check("pre_edge_after_release", 4'd0, 1'b0);
    @(posedge clk);
    #1;
    check("first_after_release_9_8", 4'd1, 1'b1);
`else
    // Reset must have no effect on the combinational build.
    apply(4'd9, 4'd8, 1'b0);
    check("rst_ignored_9_8", 4'd1, 1'b1);
    rst = 1'b0;
    apply(4'd9, 4'd8, 1'b0);
    check("add_9_8", 4'd1, 1'b1);
`endif

    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].a, tbl[i].b, tbl[i].sel);
      check(tbl[i].name, tbl[i].exp_r, tbl[i].exp_c);
    end

    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          int         sum5;
          logic [3:0] er;
          logic       ec;
          if (s == 0) begin
            sum5 = ai + bi;
            er   = 4'(sum5 % 16);
            ec   = (sum5 > 15);
          end else begin
            er   = 4'((ai - bi + 16) % 16);
            ec   = (ai >= bi);
          end
          apply(4'(ai), 4'(bi), s[0]);
          check($sformatf("sweep_sel%0d_a%0d_b%0d", s, ai, bi), er, ec);
        end
      end
    end

`ifdef CLAS_4BIT_REG_OUT_EN
    apply(4'd15, 4'd15, 1'b0);
    check("midstream_add_15_15", 4'd14, 1'b1);
    rst = 1'b1;
    apply(4'd5, 4'd3, 1'b1);
    check("midstream_reset", 4'd0, 1'b0);
    rst = 1'b0;
    apply(4'd5, 4'd3, 1'b1);
    check("after_midstream_reset_5_3", 4'd2, 1'b1);
`else
    // Toggling sel alone on fixed operands must switch the result immediately.
    apply(4'd6, 4'd9, 1'b0);
    check("sel_toggle_add_6_9", 4'd15, 1'b0);
    apply(4'd6, 4'd9, 1'b1);
    check("sel_toggle_sub_6_9", 4'd13, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clas_4_bit.md
# clas_4_bit

4-bit carry look-ahead adder/subtractor for the arithmetic-logic datapath. It computes `a + b` or `a - b` on two unsigned 4-bit operands, selected by `sel`. All carries are produced by a flat look-ahead network rather than a ripple chain. By default the result is combinational; an optional output register stage is available at compile time.

## Interface
- Parameters: none. The width is fixed at 4 bits and taken from the shared package constant.
- `clk`  input  1  — single clock. Used only when the output register is compiled in.
- `rst`  input  1  — reset, synchronous and active-high. Used only when the output register is compiled in.
- `a`  input  4  — operand A, unsigned.
- `b`  input  4  — operand B, unsigned.
- `sel`  input  1  — operation select: 0 = add, 1 = subtract.
- `result`  output  4  — sum or difference, modulo 16.
- `c_out`  output  1  — carry out of bit 3.

## Operation
- Effective B operand: `bx = b ^ {4{sel}}`. Carry-in: `c0 = sel`.
  - Subtraction is therefore `a + ~b + 1`, i.e. two's complement.
- Per bit: `g[i] = a[i] & bx[i]`, `p[i] = a[i] ^ bx[i]`.
- Carries are fully expanded, with no ripple:
  - `c1 = g0 | p0·c0`
  - `c2 = g1 | p1·g0 | p1·p0·c0`
  - `c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0`
  - `c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·c0`
- Outputs: `result[i] = p[i] ^ c[i]`, `c_out = c4`.
- Add (`sel = 0`): `result = (a + b) mod 16`; `c_out = 1` iff `a + b > 15`.
- Subtract (`sel = 1`): `result = (a - b) mod 16`; `c_out = 1` iff `a >= b` (no borrow), `c_out = 0` on borrow.
- Signed overflow is not reported.
- Every one of the 512 input combinations (`a`, `b`, `sel`) yields a defined output; there are no X states.

## Timing
- Default build: purely combinational.
  - `result` and `c_out` settle within the same evaluation as any change on `a`, `b` or `sel`.
  - `clk` and `rst` have no effect; there is no reset value and no latency.
- Registered build (see Configuration):
  - `result` and `c_out` are captured on each rising edge of `clk`, giving 1-cycle latency.
  - While `rst = 1` at a rising edge, `result = 4'h0` and `c_out = 0`; reset takes priority over capture.
  - After reset deasserts, the first valid output appears at the edge following the first sampled input.
- `sel` may change on any cycle; it has no hold requirement beyond normal setup/hold in the registered build.

## Configuration
- Macro: `CLAS_4BIT_REG_OUT_EN`.
- Defined: `result`/`c_out` are registered as described in Timing, with a synchronous active-high reset to 0.
- Undefined (default): combinational outputs; `clk`/`rst` are present but unused.

## Structure
- Shared package `clas_pkg`:
  - `CLAS_WIDTH = 4`
  - `SEL_ADD = 1'b0`, `SEL_SUB = 1'b1`
- Sub-module `clas_cla_gen`: takes `p[3:0]`, `g[3:0]` and `c0`, and returns `c[4:1]` via the expanded equations above.
- The top level contains:
  - the B-inversion XOR,
  - the per-bit `g`/`p` logic,
  - the sum XORs,
  - the optional output register.

## Test plan
- Add `a = 3`, `b = 5`, `sel = 0` → `result = 8`, `c_out = 0`.
- Add wrap `a = 15`, `b = 1`, `sel = 0` → `result = 0`, `c_out = 1`; and `a = 15`, `b = 15` → `result = 14`, `c_out = 1`.
- Subtract `a = 5`, `b = 3`, `sel = 1` → `result = 2`, `c_out = 1`; and `a = 7`, `b = 7` → `result = 0`, `c_out = 1`.
- Subtract borrow `a = 3`, `b = 5`, `sel = 1` → `result = 14`, `c_out = 0`; and `a = 0`, `b = 15` → `result = 1`, `c_out = 0`.
- Exhaustive sweep of all 256 `a`/`b` pairs for each `sel`, checked against the Operation rules:
  - `result` must equal `(a ± b) mod 16`;
  - `c_out` must equal bit 4 of `a + b` (add) or `a >= b` (subtract).
- Registered build:
  - With `rst = 1` for 2 cycles, outputs read 0.
  - Release reset, then apply `a = 9`, `b = 8`, `sel = 0` → `result = 1`, `c_out = 1` exactly one edge later.
  - Assert `rst` mid-stream → outputs read 0 at the next edge.
